// File: rtl/alu_io_pkg.sv
// alu_io_pkg: shared types and sizes for the ALU operand front end.
package alu_io_pkg;
    typedef enum logic [1:0] {IDLE, DEB_PRESS, COMMIT, DEB_RELEASE} loader_state_t;
    typedef enum logic {LOAD, CLEAR} load_kind_t;
    localparam int NUM_OPERANDS = 8;
    localparam int OPERAND_W = 4;
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs and operand slot outputs of the loader.
interface operand_loader_if
    import alu_io_pkg::*;
#(
    parameter int DATA_W = OPERAND_W
);
    logic [DATA_W-1:0] sw_data;
    logic [2:0] sw_addr;
    logic btn_load;
    logic btn_clear;
    logic [DATA_W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic load_pulse;
    logic busy;
    logic [2:0] last_addr;
    modport master (
        output sw_data, sw_addr, btn_load, btn_clear,
        input  x0, x1, x2, x3, x4, x5, x6, x7, load_pulse, busy, last_addr
    );
    modport slave (
        input  sw_data, sw_addr, btn_load, btn_clear,
        output x0, x1, x2, x3, x4, x5, x6, x7, load_pulse, busy, last_addr
    );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: debounced LOAD/CLEAR buttons writing the eight ALU operand slots.
module operand_loader
    import alu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W = OPERAND_W
) (
    input logic clk,
    input logic rst,
    operand_loader_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [1:0] btn_s;
    logic ld_s, clr_s, mon;
    loader_state_t state;
    load_kind_t kind;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] x [NUM_OPERANDS];
    sync_2ff #(.W(2)) u_sync (
        .clk(clk),
        .rst(rst),
        .d({io.btn_clear, io.btn_load}),
        .q(btn_s)
    );
    assign clr_s = btn_s[1];
    assign ld_s  = btn_s[0];
    // Only the button that started the sequence is watched until it is released.
    assign mon = (kind == CLEAR) ? clr_s : ld_s;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            kind          <= LOAD;
            cnt           <= '0;
            x             <= '{default: '0};
            io.load_pulse <= 1'b0;
            io.busy       <= 1'b0;
            io.last_addr  <= '0;
        end else begin
            io.load_pulse <= 1'b0;
            case (state)
                IDLE:
                    if (clr_s || ld_s) begin
                        state   <= DEB_PRESS;
                        kind    <= clr_s ? CLEAR : LOAD;
                        cnt     <= '0;
                        io.busy <= 1'b1;
                    end
                DEB_PRESS:
                    if (!mon) begin
                        state   <= IDLE;
                        io.busy <= 1'b0;
                    end else if (cnt == CMAX) begin
                        state         <= COMMIT;
                        io.load_pulse <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                COMMIT: begin
                    if (kind == CLEAR)
                        x <= '{default: '0};
                    else begin
                        x[io.sw_addr] <= io.sw_data;
                        io.last_addr  <= io.sw_addr;
                    end
                    state <= DEB_RELEASE;
                    cnt   <= '0;
                end
                DEB_RELEASE:
                    if (mon)
                        cnt <= '0;
                    else if (cnt == CMAX) begin
                        state   <= IDLE;
                        io.busy <= 1'b0;
                    end else
                        cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    assign io.x0 = x[0];
    assign io.x1 = x[1];
    assign io.x2 = x[2];
    assign io.x3 = x[3];
    assign io.x4 = x[4];
    assign io.x5 = x[5];
    assign io.x6 = x[6];
    assign io.x7 = x[7];
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: random and directed button sequences checked against a window-based model.
module tb_operand_loader;
    localparam int D = 4;
    localparam int W = 4;
    localparam int HMAX = 40000;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    operand_loader_if #(.DATA_W(W)) bus ();
    operand_loader #(.DEBOUNCE_CYCLES(D), .DATA_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .io(bus.slave)
    );
    int vecs = 0;
    int errs = 0;
    int pulses = 0;
    // Model: buttons seen two edges late; a press commits once the watched button
    // has been seen high on D+1 consecutive edges; release ends after D consecutive lows.
    logic [W-1:0] mx [8];
    logic [2:0] mlast;
    bit mpulse, mbusy;
    bit pl0, pl1, pc0, pc1;
    int ph, t, t0, rs;
    bit mk;
    bit mh [HMAX];
    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask
    function automatic logic [W-1:0] dx(int i);
        case (i)
            0: return bus.x0;
            1: return bus.x1;
            2: return bus.x2;
            3: return bus.x3;
            4: return bus.x4;
            5: return bus.x5;
            6: return bus.x6;
            default: return bus.x7;
        endcase
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 8; i++) mx[i] = '0;
        mlast = '0; mpulse = 0; mbusy = 0;
        pl0 = 0; pl1 = 0; pc0 = 0; pc1 = 0;
        ph = 0; t = 0; t0 = 0; rs = 0; mk = 0;
    endtask
    task automatic model_step();
        bit sl, sc, m;
        int n;
        sl = pl1; sc = pc1;
        pl1 = pl0; pc1 = pc0;
        pl0 = bus.btn_load; pc0 = bus.btn_clear;
        t++;
        if (t >= HMAX) $fatal(1, "FAIL history overflow");
        m = mk ? sc : sl;
        mh[t] = m;
        case (ph)
            0: if (sc || sl) begin ph = 1; mk = sc; t0 = t; end
            1: if (!m) ph = 0; else if (t - t0 == D) ph = 2;
            2: begin
                if (mk) for (int i = 0; i < 8; i++) mx[i] = '0;
                else begin mx[bus.sw_addr] = bus.sw_data; mlast = bus.sw_addr; end
                ph = 3; rs = t;
            end
            default: begin
                n = 0;
                for (int k = t; k > rs && !mh[k]; k--) n++;
                if (n >= D) ph = 0;
            end
        endcase
        mpulse = (ph == 2);
        mbusy = (ph != 0);
    endtask
    task automatic compare_all();
        for (int i = 0; i < 8; i++) check($sformatf("x%0d", i), 32'(dx(i)), 32'(mx[i]));
        check("load_pulse", 32'(bus.load_pulse), 32'(mpulse));
        check("busy", 32'(bus.busy), 32'(mbusy));
        check("last_addr", 32'(bus.last_addr), 32'(mlast));
    endtask
    task automatic cyc(bit l, bit c, logic [2:0] a, logic [W-1:0] d);
        @(negedge clk);
        bus.btn_load = l; bus.btn_clear = c; bus.sw_addr = a; bus.sw_data = d;
        @(posedge clk);
        if (rst) model_step();
        #1;
        if (bus.load_pulse) pulses++;
        compare_all();
    endtask
    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b0; bus.btn_load = 0; bus.btn_clear = 0;
        #1;
        model_reset();
        compare_all();
        repeat (n) begin @(posedge clk); #1; compare_all(); end
        @(negedge clk);
        rst = 1'b1;
    endtask
    task automatic press(bit l, bit c, logic [2:0] a, logic [W-1:0] d, int hold, int low);
        repeat (hold) cyc(l, c, a, d);
        repeat (low) cyc(0, 0, a, d);
    endtask
    initial begin
        int p0;
        logic [2:0] a;
        logic [W-1:0] d;
        bus.btn_load = 0; bus.btn_clear = 0; bus.sw_addr = '0; bus.sw_data = '0;
        model_reset();
        do_reset(2);
        // Load latency: pulse exactly in cycle 7, value after edge 8.
        for (int e = 1; e <= 20; e++) begin
            cyc(1, 0, 3'd5, 4'hA);
            if (e == 6) check("lat_pulse_pre", 32'(bus.load_pulse), 0);
            if (e == 7) check("lat_pulse", 32'(bus.load_pulse), 1);
            if (e == 7) check("lat_x5_pre", 32'(bus.x5), 0);
            if (e == 8) begin
                check("lat_pulse_post", 32'(bus.load_pulse), 0);
                check("lat_x5", 32'(bus.x5), 32'hA);
                check("lat_last", 32'(bus.last_addr), 5);
                check("lat_x4", 32'(bus.x4), 0);
            end
        end
        repeat (10) cyc(0, 0, 3'd5, 4'hA);
        check("lat_idle", 32'(bus.busy), 0);
        // Glitch shorter than the debounce window.
        p0 = pulses;
        press(1, 0, 3'd1, 4'h7, 3, 10);
        check("glitch_pulses", 32'(pulses - p0), 0);
        check("glitch_x1", 32'(bus.x1), 0);
        check("glitch_busy", 32'(bus.busy), 0);
        // Held button: one write, value sampled at commit.
        p0 = pulses;
        for (int e = 1; e <= 200; e++) cyc(1, 0, 3'd2, e < 50 ? 4'h9 : 4'h3);
        repeat (10) cyc(0, 0, 3'd2, 4'h3);
        check("held_pulses", 32'(pulses - p0), 1);
        check("held_x2", 32'(bus.x2), 32'h9);
        // Clear wins over load.
        press(1, 0, 3'd0, 4'h1, 10, 10);
        press(1, 0, 3'd7, 4'hF, 10, 10);
        check("pre_x7", 32'(bus.x7), 32'hF);
        p0 = pulses;
        press(1, 1, 3'd3, 4'h6, 10, 10);
        check("clr_pulses", 32'(pulses - p0), 1);
        check("clr_x0", 32'(bus.x0), 0);
        check("clr_x7", 32'(bus.x7), 0);
        check("clr_x3", 32'(bus.x3), 0);
        check("clr_last", 32'(bus.last_addr), 7);
        // Bouncy release: only one write.
        p0 = pulses;
        repeat (10) cyc(1, 0, 3'd6, 4'hC);
        for (int e = 0; e < 10; e++) cyc(e[1], 0, 3'd6, 4'hC);
        repeat (3) cyc(0, 0, 3'd6, 4'hC);
        check("bounce_busy_mid", 32'(bus.busy), 1);
        repeat (8) cyc(0, 0, 3'd6, 4'hC);
        check("bounce_pulses", 32'(pulses - p0), 1);
        check("bounce_busy", 32'(bus.busy), 0);
        check("bounce_x6", 32'(bus.x6), 32'hC);
        // Reset during press debounce aborts the write.
        repeat (5) cyc(1, 0, 3'd4, 4'hE);
        do_reset(2);
        check("rst_x6", 32'(bus.x6), 0);
        repeat (12) cyc(0, 0, 3'd4, 4'hE);
        check("rst_x4", 32'(bus.x4), 0);
        check("rst_busy", 32'(bus.busy), 0);
        // Randomised episodes.
        for (int ep = 0; ep < 60; ep++) begin
            a = 3'($urandom_range(0, 7));
            d = W'($urandom);
            case ($urandom_range(0, 5))
                0: press(1, 0, a, d, $urandom_range(1, 25), $urandom_range(0, 12));
                1: press(0, 1, a, d, $urandom_range(1, 25), $urandom_range(0, 12));
                2: press(1, 1, a, d, $urandom_range(1, 25), $urandom_range(0, 12));
                3: begin
                    repeat (12) cyc(1, 0, a, d);
                    for (int e = 0; e < 10; e++) cyc(e[1], 0, a, d);
                    repeat (8) cyc(0, 0, a, d);
                end
                4: repeat ($urandom_range(1, 10)) cyc(0, 0, 3'($urandom), W'($urandom));
                default: repeat (20) cyc(1'($urandom), 1'($urandom), a, W'($urandom));
            endcase
            if (ep == 30) begin
                repeat ($urandom_range(3, 8)) cyc(1, 0, a, d);
                do_reset(1);
            end
        end
        repeat (12) cyc(0, 0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
